// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive side of the 7-segment scan bus. Samples the multiplexed digit-enable and
//   segment lines, decodes every stable segment pattern back to a digit code, and
//   publishes one NUM_DIG-digit snapshot per capture window over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   dig_in       digit enables, one-hot; 0 = display blanked
//   seg_in       segments, bit0=a .. bit6=g, bit7=dp (dp ignored)
//   frame_ready  consumer accepts the snapshot when high together with frame_valid
//   frame_valid  snapshot on digits/digit_seen/frame_err is valid
//   digits       digit i in [4i+3:4i]; 0-9 value, 4'hA blank, 4'hF not captured/illegal
//   digit_seen   bit i set when digit i was captured at least once in the window
//   frame_err    window contained an illegal pattern or a multi-hot dig_in
//   overrun      sticky; a window ended while the previous snapshot was still unaccepted
//
// state  | meaning
// S_IDLE | waiting for the first non-blank digit enable to start window timing
// S_CAPT | window running, captures accumulate in the shadow registers
// S_PUB  | last cycle of a window: shadow goes to the outputs (or is dropped), shadow restarts

module seg_scan_decoder #(
   parameter int NUM_DIG    = 8,
   parameter int STABLE_CYC = 4,
   parameter int WINDOW     = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_DIG-1:0]     dig_in,
   input  logic [7:0]             seg_in,
   input  logic                   frame_ready,
   output logic                   frame_valid,
   output logic [4*NUM_DIG-1:0]   digits,
   output logic [NUM_DIG-1:0]     digit_seen,
   output logic                   frame_err,
   output logic                   overrun
);

   localparam int SW   = $clog2(STABLE_CYC + 1);
   localparam int WW   = $clog2(WINDOW);
   localparam int SMPW = NUM_DIG + 7;

   localparam logic [SW-1:0] STAB_TC  = SW'(STABLE_CYC);
   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CAPT = 2'd1,
      S_PUB  = 2'd2
   } state_t;

   // decimal point is not part of the digit code
   logic unused_dp;
   assign unused_dp = seg_in[7];

   logic [NUM_DIG-1:0]   dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d;
   logic [6:0]           seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
   logic [SMPW-1:0]      smp_prev_q, smp_prev_d;
   logic [SW-1:0]        stab_cnt_q, stab_cnt_d;
   state_t               state_q, state_d;
   logic [WW-1:0]        win_cnt_q, win_cnt_d;
   logic [4*NUM_DIG-1:0] sh_digits_q, sh_digits_d;
   logic [NUM_DIG-1:0]   sh_seen_q, sh_seen_d;
   logic                 sh_err_q, sh_err_d;
   logic                 frame_valid_q, frame_valid_d;
   logic [4*NUM_DIG-1:0] digits_q, digits_d;
   logic [NUM_DIG-1:0]   digit_seen_q, digit_seen_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   logic [SMPW-1:0]      smp;
   logic                 smp_same;
   logic                 cap_fire;
   logic                 dig_any;
   logic                 dig_multi;
   logic [3:0]           code;

   function automatic logic [3:0] seg_decode(input logic [6:0] s);
      logic [3:0] c;
      case (s)
         7'h3F:          c = 4'h0;
         7'h06:          c = 4'h1;
         7'h5B:          c = 4'h2;
         7'h4F:          c = 4'h3;
         7'h66:          c = 4'h4;
         7'h6D:          c = 4'h5;
         7'h7D:          c = 4'h6;
         7'h27, 7'h07:   c = 4'h7;
         7'h7F:          c = 4'h8;
         7'h67, 7'h6F:   c = 4'h9;
         7'h00:          c = 4'hA;
         default:        c = 4'hF;
      endcase
      return c;
   endfunction

   always_comb begin
      dig_s1_d      = dig_in;
      dig_s2_d      = dig_s1_q;
      seg_s1_d      = seg_in[6:0];
      seg_s2_d      = seg_s1_q;
      smp_prev_d    = smp_prev_q;
      stab_cnt_d    = stab_cnt_q;
      state_d       = state_q;
      win_cnt_d     = win_cnt_q;
      sh_digits_d   = sh_digits_q;
      sh_seen_d     = sh_seen_q;
      sh_err_d      = sh_err_q;
      frame_valid_d = frame_valid_q;
      digits_d      = digits_q;
      digit_seen_d  = digit_seen_q;
      frame_err_d   = frame_err_q;
      overrun_d     = overrun_q;

      smp        = {dig_s2_q, seg_s2_q};
      smp_same   = (smp == smp_prev_q);
      smp_prev_d = smp;
      if (smp_same) begin
         if (stab_cnt_q != STAB_TC) begin
            stab_cnt_d = stab_cnt_q + SW'(1);
         end
      end else begin
         stab_cnt_d = SW'(1);
      end
      // fire only on the transition into the terminal count, so one capture per stable run
      cap_fire  = (stab_cnt_d == STAB_TC) && !(smp_same && (stab_cnt_q == STAB_TC));
      dig_any   = |dig_s2_q;
      dig_multi = |(dig_s2_q & (dig_s2_q - NUM_DIG'(1)));
      code      = seg_decode(seg_s2_q);

      if (frame_valid_q && frame_ready) begin
         frame_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (dig_any) begin
               state_d   = S_CAPT;
               win_cnt_d = WW'(1);
            end
         end
         S_CAPT: begin
            if (win_cnt_q == WIN_LAST) begin
               state_d = S_PUB;
            end else begin
               win_cnt_d = win_cnt_q + WW'(1);
            end
         end
         S_PUB: begin
            // the publish cycle is also cycle 0 of the next window
            state_d   = S_CAPT;
            win_cnt_d = WW'(1);
            if (!frame_valid_q || frame_ready) begin
               frame_valid_d = 1'b1;
               digits_d      = sh_digits_q;
               digit_seen_d  = sh_seen_q;
               frame_err_d   = sh_err_q;
            end else begin
               overrun_d = 1'b1;
            end
            sh_digits_d = '1;
            sh_seen_d   = '0;
            sh_err_d    = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // after the publish clear so a capture in the S_PUB cycle lands in the fresh shadow
      if (cap_fire) begin
         if (dig_multi) begin
            sh_err_d = 1'b1;
         end else if (dig_any) begin
            for (int i = 0; i < NUM_DIG; i++) begin
               if (dig_s2_q[i]) begin
                  sh_digits_d[4*i +: 4] = code;
                  sh_seen_d[i]          = 1'b1;
               end
            end
            if (code == 4'hF) begin
               sh_err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dig_s1_q      <= '0;
         dig_s2_q      <= '0;
         seg_s1_q      <= '0;
         seg_s2_q      <= '0;
         smp_prev_q    <= '0;
         stab_cnt_q    <= '0;
         state_q       <= S_IDLE;
         win_cnt_q     <= '0;
         sh_digits_q   <= '1;
         sh_seen_q     <= '0;
         sh_err_q      <= 1'b0;
         frame_valid_q <= 1'b0;
         digits_q      <= '1;
         digit_seen_q  <= '0;
         frame_err_q   <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         dig_s1_q      <= dig_s1_d;
         dig_s2_q      <= dig_s2_d;
         seg_s1_q      <= seg_s1_d;
         seg_s2_q      <= seg_s2_d;
         smp_prev_q    <= smp_prev_d;
         stab_cnt_q    <= stab_cnt_d;
         state_q       <= state_d;
         win_cnt_q     <= win_cnt_d;
         sh_digits_q   <= sh_digits_d;
         sh_seen_q     <= sh_seen_d;
         sh_err_q      <= sh_err_d;
         frame_valid_q <= frame_valid_d;
         digits_q      <= digits_d;
         digit_seen_q  <= digit_seen_d;
         frame_err_q   <= frame_err_d;
         overrun_q     <= overrun_d;
      end
   end

   assign frame_valid = frame_valid_q;
   assign digits      = digits_q;
   assign digit_seen  = digit_seen_q;
   assign frame_err   = frame_err_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Scoreboard bench for seg_scan_decoder (NUM_DIG=8, STABLE_CYC=4, WINDOW=64).
//   A reference model predicts each published snapshot from the raw bus activity;
//   a monitor pops predictions whenever the DUT hands over a snapshot.

module tb_seg_scan_decoder;

   localparam int ND  = 8;
   localparam int SC  = 4;
   localparam int WIN = 64;
   localparam int SMW = ND + 7;

   logic          clk;
   logic          rst;
   logic [ND-1:0] dig_in;
   logic [7:0]    seg_in;
   logic          frame_ready;
   logic          frame_valid;
   logic [4*ND-1:0] digits;
   logic [ND-1:0] digit_seen;
   logic          frame_err;
   logic          overrun;

   seg_scan_decoder #(.NUM_DIG(ND), .STABLE_CYC(SC), .WINDOW(WIN)) dut (
      .clk         (clk),
      .rst         (rst),
      .dig_in      (dig_in),
      .seg_in      (seg_in),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .digits      (digits),
      .digit_seen  (digit_seen),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4*ND-1:0] dig;
      logic [ND-1:0]   seen;
      logic            err;
   } snap_t;

   snap_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;
   int n_push   = 0;
   int n_pops   = 0;
   bit rdy_rand = 0;

   logic [SMW-1:0]  h1, h2, prev_smp, cur;
   int              run;
   bit              m_active;
   int              m_cyc;
   logic [4*ND-1:0] sh_dig;
   logic [ND-1:0]   sh_seen;
   logic            sh_err;
   logic            m_valid = 1'b0;
   logic            m_over  = 1'b0;

   logic [4*ND-1:0] last_dig;
   logic [ND-1:0]   last_seen;
   logic            last_err;

   logic [7:0] legal_pats [13] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D,
                                   8'h27, 8'h07, 8'h7F, 8'h67, 8'h6F, 8'h00};

   function automatic logic [3:0] ref_decode(input logic [6:0] s);
      case (s)
         7'h3F: return 4'h0;
         7'h06: return 4'h1;
         7'h5B: return 4'h2;
         7'h4F: return 4'h3;
         7'h66: return 4'h4;
         7'h6D: return 4'h5;
         7'h7D: return 4'h6;
         7'h27: return 4'h7;
         7'h07: return 4'h7;
         7'h7F: return 4'h8;
         7'h67: return 4'h9;
         7'h6F: return 4'h9;
         7'h00: return 4'hA;
         default: return 4'hF;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: window timing, stable-run capture and handshake from the rules
   initial begin : ref_model
      logic [ND-1:0] d;
      logic [3:0]    c;
      bit            pub;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            h1 = '0; h2 = '0; prev_smp = '0; run = 0;
            m_active = 0; m_cyc = 0;
            sh_dig = '1; sh_seen = '0; sh_err = 1'b0;
            m_valid = 1'b0; m_over = 1'b0;
            sb.delete();
         end else begin
            cur = h2;
            h2  = h1;
            h1  = {dig_in, seg_in[6:0]};
            pub = 0;
            if (m_active) begin
               m_cyc++;
               if (m_cyc == WIN) begin
                  pub   = 1;
                  m_cyc = 0;
               end
            end else if (cur[SMW-1:7] != '0) begin
               m_active = 1;
               m_cyc    = 0;
            end
            if (pub) begin
               if (!m_valid || frame_ready) begin
                  sb.push_back('{dig: sh_dig, seen: sh_seen, err: sh_err});
                  n_push++;
                  m_valid = 1'b1;
               end else begin
                  m_over = 1'b1;
               end
               sh_dig = '1; sh_seen = '0; sh_err = 1'b0;
            end else if (m_valid && frame_ready) begin
               m_valid = 1'b0;
            end
            if (cur == prev_smp) run++;
            else run = 1;
            prev_smp = cur;
            if (run == SC) begin
               d = cur[SMW-1:7];
               if ($countones(d) > 1) begin
                  sh_err = 1'b1;
               end else if (d != '0) begin
                  c = ref_decode(cur[6:0]);
                  for (int i = 0; i < ND; i++) begin
                     if (d[i]) begin
                        sh_dig[4*i +: 4] = c;
                        sh_seen[i]       = 1'b1;
                     end
                  end
                  if (c == 4'hF) sh_err = 1'b1;
               end
            end
         end
      end
   end

   initial begin : monitor
      snap_t e;
      forever begin
         @(negedge clk);
         chk("frame_valid", 32'(frame_valid), 32'(m_valid));
         chk("overrun", 32'(overrun), 32'(m_over));
         if (frame_valid && frame_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_snapshot: got digits %h with no prediction queued", digits);
            end else begin
               e = sb.pop_front();
               chk("snap_digits", digits, e.dig);
               chk("snap_seen", 32'(digit_seen), 32'(e.seen));
               chk("snap_err", 32'(frame_err), 32'(e.err));
            end
            last_dig  = digits;
            last_seen = digit_seen;
            last_err  = frame_err;
            n_pops++;
         end
      end
   end

   task automatic step(input logic [ND-1:0] d, input logic [7:0] s, input int n);
      dig_in = d;
      seg_in = s;
      for (int k = 0; k < n; k++) begin
         if (rdy_rand) frame_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst    = 1'b0;
      dig_in = '0;
      seg_in = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic wait_pops(input int target, input string name);
      int budget = 300;
      while (n_pops < target && budget > 0) begin
         step('0, 8'h00, 1);
         budget--;
      end
      if (n_pops < target) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d snapshots expected %0d", name, n_pops, target);
      end
   endtask

   task automatic chk_last(input string name, input logic [31:0] dg, input logic [7:0] sn,
                           input logic er);
      chk({name, "_digits"}, last_dig, dg);
      chk({name, "_seen"}, 32'(last_seen), 32'(sn));
      chk({name, "_err"}, 32'(last_err), 32'(er));
   endtask

   initial begin : stim
      int base;
      int budget;
      logic [7:0] pats  [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h27};
      logic [7:0] pats2 [8] = '{8'h6F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
      logic [ND-1:0] d;
      logic [7:0]    s;

      rst = 1'b0; dig_in = '0; seg_in = '0; frame_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_digits", digits, 32'hFFFF_FFFF);
      chk("rst_seen", 32'(digit_seen), 32'h0);
      chk("rst_err", 32'(frame_err), 32'h0);
      chk("rst_valid", 32'(frame_valid), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      rst = 1'b1;

      // single digit held
      base = n_pops;
      step(8'h01, 8'h5B, 20);
      wait_pops(base + 1, "t1");
      chk_last("t1", 32'hFFFF_FFF2, 8'h01, 1'b0);

      // full round-robin scan, then the alternate 7/9 patterns
      do_reset();
      base = n_pops;
      for (int i = 0; i < ND; i++) step(8'(1 << i), pats[i], 6);
      wait_pops(base + 1, "t2a");
      chk_last("t2a", 32'h7654_3210, 8'hFF, 1'b0);
      do_reset();
      base = n_pops;
      for (int i = 0; i < ND; i++) step(8'(1 << i), pats2[i], 6);
      wait_pops(base + 1, "t2b");
      chk_last("t2b", 32'h7654_3219, 8'hFF, 1'b0);

      // glitching segments never settle long enough
      do_reset();
      base = n_pops;
      for (int k = 0; k < 20; k++) step(8'h01, (k % 2) ? 8'h06 : 8'h5B, 3);
      wait_pops(base + 1, "t3a");
      chk_last("t3a", 32'hFFFF_FFFF, 8'h00, 1'b0);
      do_reset();
      base = n_pops;
      step(8'h01, 8'h49, 20);
      wait_pops(base + 1, "t3b");
      chk_last("t3b", 32'hFFFF_FFFF, 8'h01, 1'b1);
      do_reset();
      base = n_pops;
      step(8'h03, 8'h3F, 20);
      wait_pops(base + 1, "t3c");
      chk_last("t3c", 32'hFFFF_FFFF, 8'h00, 1'b1);

      // consumer stalls across two windows
      do_reset();
      frame_ready = 1'b0;
      step(8'h01, 8'h06, 20);
      step('0, 8'h00, 120);
      chk("t4_valid", 32'(frame_valid), 32'h1);
      chk("t4_overrun", 32'(overrun), 32'h1);
      chk("t4_digits", digits, 32'hFFFF_FFF1);
      chk("t4_seen", 32'(digit_seen), 32'h01);
      frame_ready = 1'b1;
      step('0, 8'h00, 1);
      frame_ready = 1'b0;
      chk("t4_valid_drop", 32'(frame_valid), 32'h0);
      chk_last("t4", 32'hFFFF_FFF1, 8'h01, 1'b0);
      frame_ready = 1'b1;

      // accept coincides with the next publish
      do_reset();
      frame_ready = 1'b0;
      base = n_push;
      step(8'h02, 8'h4F, 20);
      budget = 300;
      while (!(n_push > base && m_active && m_cyc == WIN - 1) && budget > 0) begin
         step('0, 8'h00, 1);
         budget--;
      end
      chk("t5_reached_pub", 32'(budget > 0), 32'h1);
      frame_ready = 1'b1;
      step('0, 8'h00, 1);
      chk("t5_valid_kept", 32'(frame_valid), 32'h1);
      chk("t5_overrun", 32'(overrun), 32'h0);
      chk_last("t5a", 32'hFFFF_FF3F, 8'h02, 1'b0);
      step('0, 8'h00, 1);
      chk_last("t5b", 32'hFFFF_FFFF, 8'h00, 1'b0);

      // reset in the middle of a window
      do_reset();
      step(8'h04, 8'h66, 20);
      rst = 1'b0;
      step(8'h04, 8'h66, 3);
      chk("t6_valid", 32'(frame_valid), 32'h0);
      chk("t6_digits", digits, 32'hFFFF_FFFF);
      chk("t6_seen", 32'(digit_seen), 32'h0);
      chk("t6_overrun", 32'(overrun), 32'h0);
      rst = 1'b1;
      base = n_pops;
      step(8'h08, 8'h7F, 20);
      wait_pops(base + 1, "t6");
      chk_last("t6", 32'hFFFF_8FFF, 8'h08, 1'b0);

      // randomized bus activity with a randomly stalling consumer
      do_reset();
      rdy_rand = 1;
      for (int n = 0; n < 250; n++) begin
         int r = $urandom_range(0, 9);
         if (r < 6)      d = 8'(1 << $urandom_range(0, ND - 1));
         else if (r < 8) d = '0;
         else            d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) s = legal_pats[$urandom_range(0, 12)];
         else                           s = 8'($urandom_range(0, 255));
         step(d, s, $urandom_range(1, 8));
      end
      rdy_rand    = 0;
      frame_ready = 1'b1;
      step('0, 8'h00, 150);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      chk("snapshots_seen", 32'(n_pops > 12), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
